// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared constants and types for the spectrum bar renderer.
//   Holds the 1080p visible-area constants, the bar colour band thresholds,
//   the 12-bit {r,g,b} colour constants and the frame-update FSM state type.
package spectrum_pkg;
    localparam logic [11:0] H_VISIBLE  = 12'd1920;
    localparam logic [10:0] V_VISIBLE  = 11'd1080;
    localparam logic [10:0] GREEN_LIM  = 11'd512;
    localparam logic [10:0] YELLOW_LIM = 11'd832;
    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_WHITE  = 12'hfff;
    localparam logic [11:0] RGB_GREEN  = 12'h0f0;
    localparam logic [11:0] RGB_YELLOW = 12'hff0;
    localparam logic [11:0] RGB_RED    = 12'hf00;
    localparam logic [11:0] RGB_BG     = 12'h002;
    typedef enum logic [1:0] {ST_IDLE, ST_SWAP, ST_DECAY} frame_state_t;
endpackage

// File: rtl/spectrum_bin_ram.sv
// spectrum_bin_ram: two-bank NUM_BINS x MAG_W magnitude store.
//   clk            : clock
//   we/wr_bank/wr_addr/wr_data : write port
//   rd_bank/rd_addr : read address, rd_data valid one cycle later
// Contents are not reset; the renderer masks them until a frame is committed.
module spectrum_bin_ram #(
    parameter int NUM_BINS = 64,
    parameter int MAG_W    = 10
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic                        wr_bank,
    input  logic [$clog2(NUM_BINS)-1:0] wr_addr,
    input  logic [MAG_W-1:0]            wr_data,
    input  logic                        rd_bank,
    input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
    output logic [MAG_W-1:0]            rd_data
);
    logic [MAG_W-1:0] mem [2*NUM_BINS];

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, wr_addr}] <= wr_data;
        rd_data <= mem[{rd_bank, rd_addr}];
    end
endmodule

// File: rtl/spectrum_bar_renderer.sv
// spectrum_bar_renderer: draws one bar plus a decaying peak marker per FFT bin.
//   clk_148m, resetn : pixel clock, asynchronous active-low reset
//   x, y, visible    : raster position from the timing controller
//   bin_wr_*         : back-bank write port; bin_wr_last commits the bank
//   pix_r/g/b        : pixel colour, two cycles after x/y/visible
//   swap_pulse       : high for the cycle in which the banks swap
module spectrum_bar_renderer
    import spectrum_pkg::*;
#(
    parameter int NUM_BINS = 64,
    parameter int BAR_W    = 30,
    parameter int GAP_W    = 2,
    parameter int MAG_W    = 10,
    parameter int DECAY    = 4
) (
    input  logic                        clk_148m,
    input  logic                        resetn,
    input  logic [11:0]                 x,
    input  logic [10:0]                 y,
    input  logic                        visible,
    input  logic                        bin_wr_en,
    input  logic [$clog2(NUM_BINS)-1:0] bin_wr_addr,
    input  logic [MAG_W-1:0]            bin_wr_data,
    input  logic                        bin_wr_last,
    output logic [3:0]                  pix_r,
    output logic [3:0]                  pix_g,
    output logic [3:0]                  pix_b,
    output logic                        swap_pulse
);
    localparam int AW = $clog2(NUM_BINS);
    localparam int CW = $clog2(BAR_W);
    localparam int HW = MAG_W + 1;

    frame_state_t state_q, state_d;
    logic [AW-1:0] k_q, k_d, b_q, b_cur, s1_b, dec_k, rd_addr;
    logic [CW-1:0] c_q, c_cur, s1_c;
    logic [HW-1:0] h_cur, s1_h;
    logic [MAG_W-1:0] rd_mag, pk, dec_pk;
    logic [MAG_W-1:0] peak [NUM_BINS];
    logic [11:0] rgb;
    logic c_wrap, s1_vis, dec_v, front, has_frame, commit_pending, do_swap, hit_peak;

    // Counters hold the value for the next x; x==0 overrides so the current
    // pixel's bin/column are available without a divider.
    assign b_cur  = (x == '0) ? '0 : b_q;
    assign c_cur  = (x == '0) ? '0 : c_q;
    assign c_wrap = c_cur == CW'(BAR_W - 1);
    assign h_cur  = HW'(V_VISIBLE - 11'd1 - y);

    always_ff @(posedge clk_148m or negedge resetn) begin
        if (!resetn) begin
            b_q    <= '0;
            c_q    <= '0;
            s1_b   <= '0;
            s1_c   <= '0;
            s1_h   <= '0;
            s1_vis <= 1'b0;
        end else begin
            c_q    <= c_wrap ? '0 : c_cur + 1'b1;
            b_q    <= b_cur + AW'(c_wrap);
            s1_b   <= b_cur;
            s1_c   <= c_cur;
            s1_h   <= h_cur;
            s1_vis <= visible && (x < H_VISIBLE);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        do_swap = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = (x == '0 && y == V_VISIBLE) ? ST_SWAP : ST_IDLE;
            ST_SWAP: begin
                do_swap = commit_pending || bin_wr_last;
                k_d     = '0;
                state_d = ST_DECAY;
            end
            ST_DECAY: begin
                k_d     = k_q + 1'b1;
                state_d = (k_q == AW'(NUM_BINS - 1)) ? ST_IDLE : ST_DECAY;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign swap_pulse = do_swap;

    always_ff @(posedge clk_148m or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            k_q            <= '0;
            front          <= 1'b0;
            has_frame      <= 1'b0;
            commit_pending <= 1'b0;
            dec_v          <= 1'b0;
            dec_k          <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            front          <= front ^ do_swap;
            has_frame      <= has_frame | do_swap;
            commit_pending <= do_swap ? 1'b0 : (commit_pending | bin_wr_last);
            dec_v          <= state_q == ST_DECAY;
            dec_k          <= k_q;
        end
    end

    // DECAY owns the read port during vblank; pixels are blanked then anyway.
    assign rd_addr = (state_q == ST_DECAY) ? k_q : b_cur;

    spectrum_bin_ram #(.NUM_BINS(NUM_BINS), .MAG_W(MAG_W)) u_ram (
        .clk     (clk_148m),
        .we      (bin_wr_en),
        .wr_bank (~front),
        .wr_addr (bin_wr_addr),
        .wr_data (bin_wr_data),
        .rd_bank (front),
        .rd_addr (rd_addr),
        .rd_data (rd_mag)
    );

    // Peak update lags the DECAY read by one cycle (synchronous RAM read).
    assign dec_pk = peak[dec_k];

    always_ff @(posedge clk_148m or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_BINS; i++) peak[i] <= '0;
        end else if (dec_v) begin
            peak[dec_k] <= (rd_mag > dec_pk) ? rd_mag
                         : (dec_pk >= MAG_W'(DECAY)) ? dec_pk - MAG_W'(DECAY) : '0;
        end
    end

    assign pk       = peak[s1_b];
    assign hit_peak = (s1_h == {1'b0, pk}) || (s1_h + HW'(1) == {1'b0, pk});
    assign rgb = (!s1_vis || !has_frame || s1_c >= CW'(BAR_W - GAP_W)) ? RGB_BLACK
               : hit_peak ? RGB_WHITE
               : (s1_h < {1'b0, rd_mag}) ? ((s1_h < HW'(GREEN_LIM)) ? RGB_GREEN
                                           : (s1_h < HW'(YELLOW_LIM)) ? RGB_YELLOW : RGB_RED)
               : RGB_BG;

    always_ff @(posedge clk_148m or negedge resetn) begin
        if (!resetn) {pix_r, pix_g, pix_b} <= '0;
        else {pix_r, pix_g, pix_b} <= rgb;
    end
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// tb_spectrum_bar_renderer: directed scoreboard bench for spectrum_bar_renderer.
module tb_spectrum_bar_renderer;
    logic        clk_148m = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] x = '0;
    logic [10:0] y = '0;
    logic        visible = 1'b0;
    logic        bin_wr_en = 1'b0;
    logic [5:0]  bin_wr_addr = '0;
    logic [9:0]  bin_wr_data = '0;
    logic        bin_wr_last = 1'b0;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic        swap_pulse;

    int checks = 0;
    int errors = 0;
    logic probe_v = 1'b0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;
    logic [11:0] exp_q[$];
    int          tag_q[$];
    logic [9:0]  mags [64];

    localparam logic [11:0] BLK = 12'h000, WHT = 12'hfff, GRN = 12'h0f0,
                            YEL = 12'hff0, RED = 12'hf00, BGC = 12'h002;

    spectrum_bar_renderer dut (
        .clk_148m    (clk_148m),
        .resetn      (resetn),
        .x           (x),
        .y           (y),
        .visible     (visible),
        .bin_wr_en   (bin_wr_en),
        .bin_wr_addr (bin_wr_addr),
        .bin_wr_data (bin_wr_data),
        .bin_wr_last (bin_wr_last),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .swap_pulse  (swap_pulse)
    );

    always #5 clk_148m = ~clk_148m;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: probes issued by stimulus emerge two clocks later.
    always @(posedge clk_148m) begin
        d1 <= probe_v;
        d2 <= d1;
    end

    always @(negedge clk_148m) begin
        if (d2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pix: output with no expectation queued, got %h", {pix_r, pix_g, pix_b});
            end else begin
                logic [11:0] e;
                int t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if ({pix_r, pix_g, pix_b} !== e) begin
                    errors++;
                    $display("FAIL pix y=%0d x=%0d: got %h expected %h", t / 4096, t % 4096, {pix_r, pix_g, pix_b}, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk_148m);
        resetn = 1'b0;
        repeat (2) @(negedge clk_148m);
        resetn = 1'b1;
    endtask

    task automatic clear_mags();
        for (int i = 0; i < 64; i++) mags[i] = '0;
    endtask

    task automatic commit_frame();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_148m);
            bin_wr_en   = 1'b1;
            bin_wr_addr = 6'(i);
            bin_wr_data = mags[i];
            bin_wr_last = (i == 63);
        end
        @(negedge clk_148m);
        bin_wr_en   = 1'b0;
        bin_wr_last = 1'b0;
    endtask

    // Sweep x from 0 so the bin counters track, probing x in [xa, xb].
    task automatic line(input int yy, input int xa, input int xb, input logic vis, input logic [11:0] exp);
        for (int i = 0; i <= xb; i++) begin
            @(negedge clk_148m);
            x = 12'(i);
            y = 11'(yy);
            visible = vis;
            probe_v = (i >= xa);
            if (i >= xa) begin
                exp_q.push_back(exp);
                tag_q.push_back(yy * 4096 + i);
            end
        end
        @(negedge clk_148m);
        probe_v = 1'b0;
        visible = 1'b0;
        x = 12'(xb + 1);
    endtask

    // Vblank start, SWAP cycle (optional write+commit on it), then DECAY time.
    task automatic vblank(input logic exp_swap, input logic wr, input int wa, input int wd);
        @(negedge clk_148m);
        x = 12'd0;
        y = 11'd1080;
        visible = 1'b0;
        @(negedge clk_148m);
        x = 12'd1;
        if (wr) begin
            bin_wr_en   = 1'b1;
            bin_wr_addr = 6'(wa);
            bin_wr_data = 10'(wd);
            bin_wr_last = 1'b1;
        end
        #1 chk("swap_pulse_at_swap", 12'(swap_pulse), 12'(exp_swap));
        @(negedge clk_148m);
        x = 12'd2;
        bin_wr_en   = 1'b0;
        bin_wr_last = 1'b0;
        #1 chk("swap_pulse_after", 12'(swap_pulse), 12'd0);
        for (int i = 3; i < 75; i++) begin
            @(negedge clk_148m);
            x = 12'(i);
        end
    endtask

    initial begin
        clear_mags();
        reset_dut();
        #1 chk("reset_pix", {pix_r, pix_g, pix_b}, BLK);
        chk("reset_swap", 12'(swap_pulse), 12'd0);

        // Nothing committed: black everywhere, no swap.
        line(0, 0, 40, 1'b1, BLK);
        line(1079, 0, 40, 1'b1, BLK);
        line(500, 0, 10, 1'b0, BLK);
        vblank(1'b0, 1'b0, 0, 0);
        line(1000, 0, 40, 1'b1, BLK);

        // Single bar: bin 5 = 100, peak follows to 100.
        reset_dut();
        clear_mags();
        mags[5] = 10'd100;
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        line(1079, 150, 177, 1'b1, GRN);
        line(1079, 178, 179, 1'b1, BLK);
        line(1079, 120, 147, 1'b1, WHT);
        line(1000, 150, 177, 1'b1, GRN);
        line(1000, 120, 147, 1'b1, BGC);
        line(981, 150, 177, 1'b1, GRN);
        line(980, 150, 177, 1'b1, WHT);
        line(979, 150, 177, 1'b1, WHT);
        line(978, 150, 177, 1'b1, BGC);

        // Colour bands: bin 0 = 1023.
        reset_dut();
        clear_mags();
        mags[0] = 10'd1023;
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        line(1079, 0, 27, 1'b1, GRN);
        line(568, 10, 10, 1'b1, GRN);
        line(567, 10, 10, 1'b1, YEL);
        line(248, 10, 10, 1'b1, YEL);
        line(247, 10, 10, 1'b1, RED);
        line(58, 10, 10, 1'b1, RED);
        line(57, 0, 27, 1'b1, WHT);
        line(56, 10, 10, 1'b1, WHT);
        line(55, 10, 10, 1'b1, BGC);
        line(300, 28, 29, 1'b1, BLK);

        // Peak decay: 200, then 196, then 192.
        reset_dut();
        clear_mags();
        mags[0] = 10'd200;
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        line(879, 0, 27, 1'b1, WHT);
        line(880, 10, 10, 1'b1, WHT);
        line(881, 10, 10, 1'b1, GRN);
        clear_mags();
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        line(883, 0, 27, 1'b1, WHT);
        line(884, 10, 10, 1'b1, WHT);
        line(879, 10, 10, 1'b1, BGC);
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        line(887, 10, 10, 1'b1, WHT);
        line(888, 10, 10, 1'b1, WHT);
        line(883, 10, 10, 1'b1, BGC);

        // Write and commit on the SWAP cycle itself.
        reset_dut();
        clear_mags();
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        vblank(1'b1, 1'b1, 3, 50);
        line(1079, 90, 117, 1'b1, GRN);
        line(1079, 60, 87, 1'b1, WHT);
        line(1031, 100, 100, 1'b1, GRN);
        line(1030, 100, 100, 1'b1, WHT);
        line(1029, 100, 100, 1'b1, WHT);
        line(1028, 100, 100, 1'b1, BGC);

        // Mid-frame reset.
        reset_dut();
        clear_mags();
        mags[0] = 10'd300;
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        line(1000, 0, 27, 1'b1, GRN);
        line(500, 0, 10, 1'b1, BGC);
        repeat (3) @(negedge clk_148m);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_148m);
            x = 12'(i);
            y = 11'd500;
            visible = 1'b1;
        end
        #1 chk("pre_reset_pix", {pix_r, pix_g, pix_b}, BGC);
        @(negedge clk_148m);
        resetn = 1'b0;
        #1 chk("async_reset_pix", {pix_r, pix_g, pix_b}, BLK);
        visible = 1'b0;
        repeat (2) @(negedge clk_148m);
        resetn = 1'b1;
        line(1000, 0, 27, 1'b1, BLK);
        vblank(1'b0, 1'b0, 0, 0);
        line(1000, 0, 27, 1'b1, BLK);
        commit_frame();
        vblank(1'b1, 1'b0, 0, 0);
        line(1000, 0, 27, 1'b1, GRN);

        repeat (4) @(negedge clk_148m);
        chk("scoreboard_drained", 12'(exp_q.size()), 12'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
